// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect input
// and the instruction handshake toward the datapath.
interface fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read, credit-limited prefetch
// queue of {instruction, pc}, redirect flush. Define FETCH_BYPASS_EN for the empty-queue bypass.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_q, addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pcs_q  [DEPTH];

  logic empty_s, ack_ok_s, bypass_s, inst_valid_s, pop_s, push_s, credit_s, mem_req_s;

  // Next-state, queue bookkeeping and request generation
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_req_s  = 1'b0;

    empty_s      = (count_q == {CNT_W{1'b0}});
    ack_ok_s     = !rst && (state_q == REQ) && bus.mem_ack && !bus.redirect;
    bypass_s     = BYPASS && empty_s && ack_ok_s;
    inst_valid_s = !rst && (!empty_s || bypass_s);
    pop_s        = inst_valid_s && !empty_s && bus.inst_ready;
    push_s       = ack_ok_s && !(bypass_s && bus.inst_ready);
    // No request is outstanding in IDLE, so the credit is occupancy net of this cycle's pop
    credit_s     = (count_q < FULL) || pop_s;

    case (state_q)
      IDLE: begin
        if (credit_s && !bus.redirect) begin
          mem_req_s = 1'b1;
          addr_d    = fetch_pc_q;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        mem_req_s = 1'b1;
        if (bus.mem_ack) begin
          state_d = IDLE;
          if (!bus.redirect) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            fetch_pc_d = fetch_pc_q;
          end
        end else if (bus.redirect) begin
          state_d = DISCARD;
        end else begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        mem_req_s = 1'b1;
        if (bus.mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_d   = wr_ptr_q;
      count_d    = {CNT_W{1'b0}};
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    mem_req_s = mem_req_s && !rst;
  end

  // State, pointers and queue storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0000_0000;
        pcs_q[i]  <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push_s) begin
        data_q[wr_ptr_q] <= bus.mem_rdata;
        pcs_q[wr_ptr_q]  <= addr_q;
      end
    end
  end

  // While a request is in flight the address comes from its own latch, so a redirect cannot disturb it
  assign bus.mem_req    = mem_req_s;
  assign bus.mem_addr   = rst ? RESET_PC : ((state_q == IDLE) ? fetch_pc_q : addr_q);
  assign bus.inst_valid = inst_valid_s;
  assign bus.inst_out   = rst ? 32'h0000_0000 : (bypass_s ? bus.mem_rdata : data_q[rd_ptr_q]);
  assign bus.inst_pc    = rst ? 32'h0000_0000 : (bypass_s ? addr_q : pcs_q[rd_ptr_q]);
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  fetch_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply this cycle's inputs, then settle before sampling
  task automatic drive(input logic r, input logic [31:0] rpc, input logic a,
                       input logic [31:0] rd, input logic rdy);
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.mem_ack     = a;
    bus.mem_rdata   = rd;
    bus.inst_ready  = rdy;
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h40, 1'b1, 32'hFFFF_FFFF, 1'b1);
    repeat (3) cyc();
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_out !== 32'h0) begin n_err++; $display("FAIL rst_inst_out: got %h want 0", bus.inst_out); end
    n_cmp++; if (bus.inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc: got %h want 0", bus.inst_pc); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_sequential();
    int          req_cyc[$];
    logic [31:0] req_addr[$], hs_pc[$], hs_data[$], sent[$];
    logic        pend, a;
    logic [31:0] d;
    do_reset(1'b1);
    pend = 1'b0; a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin cyc(); a = pend; d = $urandom; drive(1'b0, 32'h0, a, d, 1'b1); if (a) sent.push_back(d); end
      if (bus.mem_req === 1'b1 && !pend && !a) begin req_cyc.push_back(c); req_addr.push_back(bus.mem_addr); end
      if (bus.inst_valid === 1'b1) begin hs_pc.push_back(bus.inst_pc); hs_data.push_back(bus.inst_out); end
      pend = (bus.mem_req === 1'b1) && !a;
    end
    n_cmp++; if (req_addr.size() < 3 || hs_pc.size() < 3) begin
      n_err++; $display("FAIL seq_count: got reqs=%0d xfers=%0d want >=3 each", req_addr.size(), hs_pc.size()); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (req_addr[k] !== 32'(4 * k) || req_cyc[k] != 2 * k) begin
        n_err++; $display("FAIL seq_req%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d", k, req_addr[k], req_cyc[k], 32'(4 * k), 2 * k); end
      n_cmp++; if (hs_pc[k] !== 32'(4 * k) || hs_data[k] !== sent[k]) begin
        n_err++; $display("FAIL seq_xfer%0d: got pc=%h data=%h want pc=%h data=%h", k, hs_pc[k], hs_data[k], 32'(4 * k), sent[k]); end
    end
  endtask

  task automatic test_full();
    logic pend, a;
    int   acks;
    do_reset(1'b0);
    pend = 1'b0; a = 1'b0; acks = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin cyc(); a = pend; drive(1'b0, 32'h0, a, 32'h1000 + 32'(c), 1'b0); end
      if (a) acks++;
      pend = (bus.mem_req === 1'b1) && !a;
    end
    n_cmp++; if (acks != DEPTH || bus.mem_req !== 1'b0) begin
      n_err++; $display("FAIL full_credit: got acks=%0d req=%b want acks=%0d req=0", acks, bus.mem_req, DEPTH); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL full_pop: got valid=%b pc=%h want valid=1 pc=0", bus.inst_valid, bus.inst_pc); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h10}) begin
      n_err++; $display("FAIL full_rereq: got req=%b addr=%h want req=1 addr=10", bus.mem_req, bus.mem_addr); end
    n_cmp++; if ({bus.inst_valid, bus.inst_pc} !== {1'b1, 32'h4}) begin
      n_err++; $display("FAIL full_head: got valid=%b pc=%h want valid=1 pc=4", bus.inst_valid, bus.inst_pc); end
  endtask

  task automatic test_redirect_pending();
    logic pend, a, found;
    do_reset(1'b1);
    pend = 1'b0; a = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c > 0) begin cyc(); a = pend; drive(1'b0, 32'h0, a, $urandom, 1'b1); end
      if (bus.mem_req === 1'b1 && !pend && !a && bus.mem_addr === 32'h8) found = 1'b1;
      pend = (bus.mem_req === 1'b1) && !a;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL redir_setup: got found=%b want 1 within 20 cycles", found); end
    cyc(); drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h8}) begin
      n_err++; $display("FAIL redir_hold0: got req=%b addr=%h want req=1 addr=8", bus.mem_req, bus.mem_addr); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({bus.mem_req, bus.mem_addr, bus.inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
      n_err++; $display("FAIL redir_hold1: got req=%b addr=%h valid=%b want 1/8/0", bus.mem_req, bus.mem_addr, bus.inst_valid); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cyc(); drive(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_drop: got valid=%b want 0", bus.inst_valid); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL redir_next: got valid=%b req=%b addr=%h want 0/1/100", bus.inst_valid, bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_redirect_ack_pop();
    logic        pend, a, found;
    logic [31:0] d, first;
    int          acks;
    do_reset(1'b0);
    pend = 1'b0; a = 1'b0; found = 1'b0; acks = 0; first = 32'h0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) begin
        cyc(); a = pend; d = $urandom; drive(1'b0, 32'h0, a, d, 1'b0);
        if (a) begin if (acks == 0) first = d; acks++; end
      end
      if (acks == DEPTH - 1 && bus.mem_req === 1'b1 && !pend && !a) found = 1'b1;
      pend = (bus.mem_req === 1'b1) && !a;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rap_setup: got found=%b acks=%0d want 1", found, acks); end
    cyc(); drive(1'b1, 32'h203, 1'b1, 32'hBAD0_0001, 1'b1);
    n_cmp++; if ({bus.inst_valid, bus.inst_pc, bus.inst_out} !== {1'b1, 32'h0, first}) begin
      n_err++; $display("FAIL rap_xfer: got valid=%b pc=%h out=%h want 1/0/%h", bus.inst_valid, bus.inst_pc, bus.inst_out, first); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      n_err++; $display("FAIL rap_next: got valid=%b req=%b addr=%h want 0/1/200", bus.inst_valid, bus.mem_req, bus.mem_addr); end
  endtask

  task automatic test_reset_mid();
    logic pend, a, found;
    do_reset(1'b1);
    pend = 1'b0; a = 1'b0; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (c > 0) begin cyc(); a = pend; drive(1'b0, 32'h0, a, $urandom, 1'b1); end
      if (bus.mem_req === 1'b1 && !pend && !a && bus.mem_addr === 32'h8) found = 1'b1;
      pend = (bus.mem_req === 1'b1) && !a;
    end
    cyc(); rst = 1'b1; drive(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
    n_cmp++; if ({bus.inst_valid, bus.mem_req} !== {1'b0, 1'b0}) begin
      n_err++; $display("FAIL rmid_in_rst: got valid=%b req=%b want 0/0 (found=%b)", bus.inst_valid, bus.mem_req, found); end
    cyc(); rst = 1'b0; drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL rmid_release: got valid=%b req=%b addr=%h want 0/1/0", bus.inst_valid, bus.mem_req, bus.mem_addr); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rmid_after: got valid=%b want 0", bus.inst_valid); end
  endtask

  task automatic test_bypass();
    do_reset(1'b0);
    cyc(); drive(1'b0, 32'h0, 1'b1, 32'h0050_0093, 1'b0);
    n_cmp++; if (bus.inst_valid !== BYP) begin n_err++; $display("FAIL byp_ack_cycle: got valid=%b want %b", bus.inst_valid, BYP); end
    cyc(); drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    n_cmp++; if ({bus.inst_valid, bus.inst_out, bus.inst_pc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
      n_err++; $display("FAIL byp_next: got valid=%b out=%h pc=%h want 1/00500093/0", bus.inst_valid, bus.inst_out, bus.inst_pc); end
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [31:0] fpc, oaddr, rpc, rd, epc, eout;
    logic        outst, drop, r, a, rdy, ebyp, evalid, epop, ereq, newreq;
    int          occ;
    do_reset(1'b0);
    fpc = 32'h0; oaddr = 32'h0; outst = 1'b0; drop = 1'b0;
    r = 1'b0; a = 1'b0; rdy = 1'b0; rpc = 32'h0; rd = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        cyc();
        r   = ($urandom_range(0, 19) == 0);
        rpc = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 31))) : $urandom;
        a   = outst && ($urandom_range(0, 2) == 0);
        rd  = $urandom;
        rdy = ($urandom_range(0, 1) == 1);
        drive(r, rpc, a, rd, rdy);
      end
      ebyp   = BYP && (q.size() == 0) && outst && !drop && a && !r;
      evalid = (q.size() != 0) || ebyp;
      n_cmp++; if (bus.inst_valid !== evalid) begin
        n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, bus.inst_valid, evalid); end
      if (evalid) begin
        epc  = ebyp ? oaddr : q[0][63:32];
        eout = ebyp ? rd : q[0][31:0];
        n_cmp++; if ({bus.inst_pc, bus.inst_out} !== {epc, eout}) begin
          n_err++; $display("FAIL rnd_head c=%0d: got pc=%h out=%h want pc=%h out=%h", c, bus.inst_pc, bus.inst_out, epc, eout); end
      end
      epop = evalid && rdy;
      if (outst) begin
        n_cmp++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, oaddr}) begin
          n_err++; $display("FAIL rnd_hold c=%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.mem_req, bus.mem_addr, oaddr); end
      end else if (!r) begin
        occ  = q.size() - (epop ? 1 : 0);
        ereq = (occ < DEPTH);
        n_cmp++; if (bus.mem_req !== ereq || (ereq && bus.mem_addr !== fpc)) begin
          n_err++; $display("FAIL rnd_req c=%0d: got req=%b addr=%h want req=%b addr=%h", c, bus.mem_req, bus.mem_addr, ereq, fpc); end
      end
      newreq = !outst && (bus.mem_req === 1'b1);
      if (epop && q.size() != 0) void'(q.pop_front());
      if (r) begin
        q.delete();
        if (outst && a) begin outst = 1'b0; drop = 1'b0; end
        else if (outst) drop = 1'b1;
        if (newreq) begin outst = 1'b1; oaddr = fpc; drop = 1'b1; end
        fpc = {rpc[31:2], 2'b00};
      end else if (outst && a) begin
        if (!drop) begin
          if (!(ebyp && rdy)) q.push_back({oaddr, rd});
          fpc = oaddr + 32'd4;
        end
        outst = 1'b0; drop = 1'b0;
      end else if (newreq) begin
        outst = 1'b1; oaddr = fpc; drop = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port mem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port mem_ack  input  1  memory completes request; mem_rdata valid this cycle.
REQ-008 SHALL have port mem_rdata  input  32  returned instruction word.
REQ-009 SHALL have port redirect  input  1  taken branch/jump; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 SHALL have port inst_valid  output  1  inst_out/inst_pc valid to datapath.
REQ-012 SHALL have port inst_ready  input  1  datapath accepts instruction.
REQ-013 SHALL have port inst_out  output  32  instruction word at queue head.
REQ-014 SHALL have port inst_pc  output  32  address of inst_out.

Function
REQ-015 SHALL store {instruction, pc} pairs in a DEPTH-entry FIFO; head presented on inst_out/inst_pc.
REQ-016 SHALL transfer an instruction on any cycle with inst_valid=1 and inst_ready=1; inst_valid=1 exactly when FIFO non-empty (or bypass per REQ-032).
REQ-017 SHALL keep at most one memory request outstanding.
REQ-018 SHALL assert mem_req only when occupancy + outstanding < DEPTH (credit rule), counting a same-cycle pop as freeing an entry.
REQ-019 Once mem_req=1, mem_req and mem_addr SHALL hold stable until the cycle mem_ack=1, including across redirect.
REQ-020 On mem_ack, fetch_pc SHALL advance by 4 (32-bit wrap from 32'hFFFF_FFFC to 0); mem_req MAY reassert the next cycle (no back-to-back in the ack cycle).
REQ-021 SHALL implement FSM IDLE, REQ, DISCARD: IDLE->REQ when credit available; REQ->IDLE on mem_ack; REQ->DISCARD on redirect without mem_ack; DISCARD->IDLE on mem_ack, response dropped.
REQ-022 On redirect: FIFO emptied same edge, fetch_pc <= {redirect_pc[31:2],2'b00}, inst_valid=0 next cycle.
REQ-023 Redirect coincident with mem_ack SHALL drop that response and go to IDLE.
REQ-024 Redirect coincident with a handshake SHALL complete that transfer; redirect has priority over every push.
REQ-025 Full FIFO with push and pop same cycle SHALL keep occupancy DEPTH, no loss; empty FIFO never pops.
REQ-026 Response latency SHALL be arbitrary (>=1 cycle after mem_req asserted); no timeout.

Reset
REQ-027 While rst=1: mem_req=0, inst_valid=0, FIFO empty, FSM=IDLE, fetch_pc=RESET_PC, mem_addr=RESET_PC, inst_out=0, inst_pc=0.
REQ-028 First mem_req SHALL assert the first cycle after rst deasserts, mem_addr=RESET_PC.
REQ-029 rst during an outstanding request SHALL abandon it; a mem_ack arriving in the rst cycle is ignored.
REQ-030 rst SHALL take priority over redirect, mem_ack and handshake.

Configuration
REQ-031 Macro FETCH_BYPASS_EN SHALL select the empty-queue bypass path.
REQ-032 With FETCH_BYPASS_EN defined: FIFO empty and mem_ack (not discarded, no redirect) SHALL drive inst_valid=1, inst_out=mem_rdata, inst_pc=mem_addr same cycle; if inst_ready=1 the word is not written to the FIFO.
REQ-033 Without FETCH_BYPASS_EN: every response is written to FIFO; earliest inst_valid is the cycle after mem_ack; inst_valid/inst_out/inst_pc are registered.

Verification
REQ-034 Reset release, mem_ack 1 cycle after each request, inst_ready=1 -> mem_addr 0x0,0x4,0x8 in order; inst_pc matches each; no gaps beyond REQ-020.
REQ-035 inst_ready=0, DEPTH=4 -> exactly 4 acks accepted, mem_req stays 0; inst_ready=1 one cycle -> one pop, mem_req reasserts next cycle at 0x10.
REQ-036 Redirect to 0x100 while request for 0x8 outstanding, ack 3 cycles later with 0xDEADBEEF -> word dropped, inst_valid=0, next mem_addr=0x100.
REQ-037 Redirect to 0x203 coincident with mem_ack and full-FIFO pop -> popped word delivered, ack dropped, FIFO empty, next mem_addr=0x200.
REQ-038 rst asserted mid-request with mem_ack same cycle -> no inst_valid, next mem_req at RESET_PC.
REQ-039 Both macro settings, empty FIFO, ack of 0x00500093 at 0x0 -> inst_valid same cycle (bypass) or next cycle (no bypass), inst_pc=0x0.
